// File: rtl/fifo_traffic_check.sv
// FIFO traffic generator and checker.
// Writes a deterministic word sequence into a FIFO under test and checks the
// words read back against the same sequence. Mismatches are counted and the
// first one is captured. A reset sequence for the FIFO runs on request or
// periodically, using a toggle request/done handshake.
module fifo_traffic_check #(
  parameter int W          = 16,
  parameter int CNT_W      = 16,
  parameter int RST_PERIOD = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [3:0]       w_throttle,
  input  logic [3:0]       r_throttle,
  input  logic             rst_req,
  output logic             w_trigger,
  output logic [W-1:0]     w_data,
  input  logic             w_ready,
  output logic             r_trigger,
  input  logic [W-1:0]     r_data,
  input  logic             r_ready,
  output logic             fifo_rst,
  input  logic             fifo_rst_done,
  output logic             busy,
  output logic             err,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] rd_count,
  output logic [W-1:0]     exp_data,
  output logic [W-1:0]     got_data
);

  localparam logic [1:0] S_RUN  = 2'd0;
  localparam logic [1:0] S_STOP = 2'd1;
  localparam logic [1:0] S_RST  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  // Period counter only needs to reach RST_PERIOD-1.
  localparam int PW = (RST_PERIOD > 1) ? $clog2(RST_PERIOD) : 1;

  function automatic logic [W-1:0] seed_of(input logic [1:0] m);
    case (m)
      2'd1:    return '1;
      2'd2:    return W'(1);
      default: return '0;
    endcase
  endfunction

  function automatic logic [W-1:0] next_of(input logic [1:0] m, input logic [W-1:0] v);
    case (m)
      2'd1:    return v - W'(1);
      2'd2:    return {v[W-2:0], v[W-1]};
      default: return v + W'(1);
    endcase
  endfunction

  // Mode 3 presents the counter value as Gray code.
  function automatic logic [W-1:0] out_of(input logic [1:0] m, input logic [W-1:0] v);
    return (m == 2'd3) ? (v ^ (v >> 1)) : v;
  endfunction

  logic [1:0]    state, state_next;
  logic [1:0]    mode_q;
  logic [W-1:0]  g, e;
  logic [3:0]    p, p_next;
  logic [PW-1:0] per_cnt;
  logic          sync1, sync2, sync3;
  logic          done_edge;
  logic          period_hit;
  logic          run_next;
  logic          w_xfer, r_xfer;
  logic          mismatch;

  assign p_next     = p + 4'd1;
  assign done_edge  = sync2 ^ sync3;
  assign period_hit = (RST_PERIOD != 0) && (per_cnt == PW'(RST_PERIOD - 1));
  assign run_next   = (state_next == S_RUN);
  assign w_xfer     = w_trigger & w_ready;
  assign r_xfer     = r_trigger & r_ready;
  assign mismatch   = r_xfer && (r_data != out_of(mode_q, e));
  assign w_data     = out_of(mode_q, g);
  assign busy       = (state != S_RUN);

  // Next-state decode for the FIFO reset sequencer.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      S_RUN:   if (rst_req || period_hit) state_next = S_STOP;
      S_STOP:  state_next = S_RST;
      S_RST:   state_next = S_WAIT;
      S_WAIT:  if (done_edge) state_next = S_RUN;
      default: state_next = S_RUN;
    endcase
  end

  // Sequencer state, throttle phase, period counter, reset toggle and the
  // registered strobes (computed from the next state so they drop in STOP).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RUN;
      p         <= '0;
      per_cnt   <= '0;
      fifo_rst  <= 1'b0;
      w_trigger <= 1'b0;
      r_trigger <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state     <= state_next;
      p         <= p_next;
      per_cnt   <= (state == S_RUN && run_next) ? per_cnt + PW'(1) : '0;
      fifo_rst  <= fifo_rst ^ (state == S_RST);
      w_trigger <= run_next && en && (p_next >= w_throttle);
      r_trigger <= run_next && en && (p_next >= r_throttle);
    end
  end

  // Two-flop synchroniser plus one history flop for edge detection of the
  // asynchronous done toggle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= fifo_rst_done;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // Generator and checker sequence registers; both restart from the seed of
  // the freshly latched mode when a FIFO reset completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= mode;
      g      <= seed_of(mode);
      e      <= seed_of(mode);
    end else if (state == S_WAIT && done_edge) begin
      mode_q <= mode;
      g      <= seed_of(mode);
      e      <= seed_of(mode);
    end else begin
      if (w_xfer) g <= next_of(mode_q, g);
      if (r_xfer) e <= next_of(mode_q, e);
    end
  end

  // Read accounting and mismatch reporting; the first mismatch is captured
  // and held until rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count  <= '0;
      err_count <= '0;
      err       <= 1'b0;
      exp_data  <= '0;
      got_data  <= '0;
    end else begin
      if (r_xfer) rd_count <= rd_count + CNT_W'(1);
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + CNT_W'(1);
        if (!err) begin
          err      <= 1'b1;
          exp_data <= out_of(mode_q, e);
          got_data <= r_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_traffic_check.sv
// Bench for fifo_traffic_check: two instances (no automatic reset, and a
// 64-cycle reset period), each attached to an ideal 4-deep FIFO model that
// can drop one chosen word and answers fifo_rst with a delayed done toggle.
module tb_fifo_traffic_check;

  localparam int DONE_DLY = 10;

  logic clk = 1'b0;
  logic rst, en, rst_req;
  logic [1:0] mode;
  logic [3:0] wt, rt;
  int drop_idx;

  logic [1:0]       w_trigger, w_ready, r_trigger, r_ready;
  logic [1:0]       fifo_rst, fifo_rst_done, busy, err;
  logic [1:0][7:0]  w_data, r_data, exp_data, got_data;
  logic [1:0][15:0] err_count, rd_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] wlog[$];
  logic [7:0] rlog[$];

  typedef struct packed {
    logic [1:0]  mode;
    logic [71:0] words;   // word j at bits [8*j +: 8]
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_inst
    fifo_traffic_check #(.W(8), .CNT_W(16), .RST_PERIOD((i == 0) ? 0 : 64)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode),
      .w_throttle(wt), .r_throttle(rt), .rst_req(rst_req),
      .w_trigger(w_trigger[i]), .w_data(w_data[i]), .w_ready(w_ready[i]),
      .r_trigger(r_trigger[i]), .r_data(r_data[i]), .r_ready(r_ready[i]),
      .fifo_rst(fifo_rst[i]), .fifo_rst_done(fifo_rst_done[i]),
      .busy(busy[i]), .err(err[i]), .err_count(err_count[i]),
      .rd_count(rd_count[i]), .exp_data(exp_data[i]), .got_data(got_data[i])
    );

    logic [7:0] mem [4];
    logic [2:0] cnt;
    logic [1:0] wp, rp;
    int         wr_num, dly;
    logic       fr_prev, done, do_w, do_r, keep;

    assign w_ready[i]       = (cnt < 3'd4);
    assign r_ready[i]       = (cnt != 3'd0);
    assign r_data[i]        = mem[rp];
    assign fifo_rst_done[i] = done;
    assign do_w = w_trigger[i] && w_ready[i];
    assign do_r = r_trigger[i] && r_ready[i];
    assign keep = do_w && (wr_num != drop_idx);

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= 0; wp <= 0; rp <= 0; wr_num <= 0; dly <= 0; fr_prev <= 0; done <= 0;
      end else begin
        fr_prev <= fifo_rst[i];
        if (fifo_rst[i] != fr_prev) begin
          cnt <= 0; wp <= 0; rp <= 0; wr_num <= 0; dly <= DONE_DLY;
        end else begin
          if (keep) begin mem[wp] <= w_data[i]; wp <= wp + 2'd1; end
          if (do_w) wr_num <= wr_num + 1;
          if (do_r) rp <= rp + 2'd1;
          cnt <= cnt + {2'b0, keep} - {2'b0, do_r};
          if (dly > 0) begin
            dly <= dly - 1;
            if (dly == 1) done <= ~done;
          end
        end
      end
    end
  end

  // Transfer log of instance 0.
  always @(posedge clk) begin
    if (!rst) begin
      if (w_trigger[0] && w_ready[0]) wlog.push_back(w_data[0]);
      if (r_trigger[0] && r_ready[0]) rlog.push_back(r_data[0]);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic do_reset(input logic [1:0] m);
    @(negedge clk);
    en = 1'b0; rst_req = 1'b0; mode = m; rst = 1'b1;
    repeat (3) @(negedge clk);
    wlog.delete(); rlog.delete();
    rst = 1'b0;
  endtask

  task automatic pulse_req();
    rst_req = 1'b1;
    @(negedge clk);
    rst_req = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, bad, maxw, sum, rd0, tog_n, tog_at, viol, busy_n;
    logic prev, found;
    bit hist[160];

    vecs[0] = '{mode: 2'd0, words: 72'h08_07_06_05_04_03_02_01_00};
    vecs[1] = '{mode: 2'd1, words: 72'hF7_F8_F9_FA_FB_FC_FD_FE_FF};
    vecs[2] = '{mode: 2'd2, words: 72'h01_80_40_20_10_08_04_02_01};
    vecs[3] = '{mode: 2'd3, words: 72'h0C_04_05_07_06_02_03_01_00};

    // Reset values (mode 1: seed all-ones visible on w_data).
    rst = 1'b1; en = 1'b0; mode = 2'd1; wt = 0; rt = 0; rst_req = 1'b0; drop_idx = -1;
    repeat (2) @(negedge clk);
    check("rst_w_trigger", w_trigger, 0);
    check("rst_r_trigger", r_trigger, 0);
    check("rst_fifo_rst", fifo_rst, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count[0], 0);
    check("rst_rd_count", rd_count[0], 0);
    check("rst_exp_data", exp_data[0], 0);
    check("rst_got_data", got_data[0], 0);
    check("rst_w_data_seed", w_data[0], 8'hFF);
    en = 1'b1; rst = 1'b0;
    @(negedge clk);
    check("first_cycle_w_trigger", w_trigger[0], 1);
    check("first_cycle_r_trigger", r_trigger[0], 1);
    check("first_cycle_w_data", w_data[0], 8'hFF);

    // 300 reads in mode 0: 00..FF then 00..2B.
    do_reset(2'd0); en = 1'b1;
    for (c = 0; c < 2000 && rlog.size() < 300; c++) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("long_timeout", (rlog.size() >= 300), 1);
    bad = 0;
    for (int j = 0; j < 300 && j < rlog.size(); j++)
      if (rlog[j] != 8'(j)) bad++;
    check("long_order_errors", bad, 0);
    check("long_word_256", (rlog.size() > 256) ? rlog[256] : 8'hEE, 8'h00);
    check("long_word_299", (rlog.size() > 299) ? rlog[299] : 8'hEE, 8'h2B);
    check("long_err", err[0], 0);
    check("long_rd_count", rd_count[0], rlog.size());

    // Sequence table; mode input changes after release to prove it is latched.
    for (int k = 0; k < 4; k++) begin
      do_reset(vecs[k].mode);
      mode = ~vecs[k].mode; en = 1'b1;
      for (c = 0; c < 200 && wlog.size() < 9; c++) @(negedge clk);
      repeat (10) @(negedge clk);
      check($sformatf("seq%0d_timeout", k), (wlog.size() >= 9), 1);
      for (int j = 0; j < 9; j++)
        check($sformatf("seq%0d_word%0d", k, j), (wlog.size() > j) ? wlog[j] : 8'hEE,
              vecs[k].words[8*j +: 8]);
      check($sformatf("seq%0d_err", k), err[0], 0);
    end

    // Dropped 5th word: got 05 against expected 04.
    do_reset(2'd0); drop_idx = 4; en = 1'b1;
    found = 1'b0;
    for (c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (r_trigger[0] && r_ready[0] && rlog.size() == 4) found = 1'b1;
    end
    check("drop_found", found, 1);
    check("drop_err_before", err[0], 0);
    @(negedge clk);
    check("drop_err_after", err[0], 1);
    check("drop_exp_data", exp_data[0], 8'h04);
    check("drop_got_data", got_data[0], 8'h05);
    check("drop_err_count_first", err_count[0], 1);
    repeat (20) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    check("drop_err_count_final", err_count[0], rlog.size() - 4);
    check("drop_exp_sticky", exp_data[0], 8'h04);
    check("drop_got_sticky", got_data[0], 8'h05);
    drop_idx = -1;

    // Automatic reset on instance 1 after 64 RUN cycles.
    do_reset(2'd0); en = 1'b1;
    for (c = 1; c < 300; c++) begin
      @(negedge clk);
      if (busy[1]) break;
    end
    check("period_stop_cycle", c, 64);
    prev = fifo_rst[1]; tog_n = 0; tog_at = -1; viol = 0; c = 0;
    while (busy[1] && c < 100) begin
      if (w_trigger[1] || r_trigger[1]) viol++;
      if (fifo_rst[1] != prev) begin
        tog_n++;
        if (tog_at < 0) tog_at = c;
        prev = fifo_rst[1];
      end
      @(negedge clk); c++;
    end
    check("period_busy_timeout", (c < 100), 1);
    check("period_trigger_while_busy", viol, 0);
    check("period_fifo_rst_toggles", tog_n, 1);
    check("period_fifo_rst_delay", tog_at, 2);
    check("period_first_w_trigger", w_trigger[1], 1);
    check("period_first_w_data", w_data[1], 8'h00);
    rd0 = rd_count[1];
    repeat (20) @(negedge clk);
    check("period_reads_after", (rd_count[1] != 16'(rd0)), 1);
    check("period_err", err[1], 0);

    // rst_req during WAIT is ignored.
    do_reset(2'd0); en = 1'b1;
    repeat (5) @(negedge clk);
    pulse_req();
    check("req_busy", busy[0], 1);
    for (c = 0; c < 20 && !fifo_rst[0]; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("req_in_wait", busy[0], 1);
    pulse_req();
    for (c = 0; c < 50 && busy[0]; c++) @(negedge clk);
    check("req_wait_timeout", busy[0], 0);
    busy_n = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (busy[0]) busy_n++;
    end
    check("req_ignored_busy", busy_n, 0);
    check("req_single_toggle", fifo_rst[0], 1);
    check("req_err", err[0], 0);

    // Async rst while in WAIT.
    do_reset(2'd0); en = 1'b1;
    repeat (5) @(negedge clk);
    pulse_req();
    for (c = 0; c < 20 && !fifo_rst[0]; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    check("wait_rst_pre_busy", busy[0], 1);
    #2 rst = 1'b1;
    #1;
    check("wait_rst_fifo_rst", fifo_rst[0], 0);
    check("wait_rst_busy", busy[0], 0);
    check("wait_rst_w_trigger", w_trigger[0], 0);
    @(negedge clk);
    wlog.delete(); rlog.delete();
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("wait_rst_first_w", (wlog.size() > 0) ? wlog[0] : 8'hEE, 8'h00);
    check("wait_rst_first_r", (rlog.size() > 0) ? rlog[0] : 8'hEE, 8'h00);
    check("wait_rst_busy_after", busy[0], 0);
    check("wait_rst_err", err[0], 0);

    // Write throttle 12: at most 4 strobes in any 16 consecutive cycles.
    do_reset(2'd0); wt = 4'd12; rt = 4'd0; en = 1'b1;
    for (int j = 0; j < 160; j++) begin
      @(negedge clk);
      hist[j] = w_trigger[0];
    end
    en = 1'b0;
    repeat (5) @(negedge clk);
    maxw = 0;
    for (int j = 0; j <= 144; j++) begin
      sum = 0;
      for (int k = 0; k < 16; k++) sum += int'(hist[j+k]);
      if (sum > maxw) maxw = sum;
    end
    check("thr_max_per_16", (maxw <= 4), 1);
    check("thr_some_writes", (wlog.size() >= 8), 1);
    bad = 0;
    for (int j = 0; j < rlog.size(); j++)
      if (rlog[j] != 8'(j)) bad++;
    check("thr_order_errors", bad, 0);
    check("thr_err", err[0], 0);
    wt = 4'd0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_traffic_check.md
# fifo_traffic_check

Single-clock, parametrised FIFO traffic generator and checker. It drives the write port of a FIFO under test with a deterministic data sequence and checks the read port against the same sequence. It periodically sequences a full FIFO reset through a toggle request/done handshake and reports mismatches through sticky and counted status. It is the reusable successor to the ad-hoc FIFO bring-up harnesses: width, sequence mode, throttle and reset period are configurable, and the first word after every reset is checked.

## Interface
Parameters:
- W, 16: data width, 2..32.
- CNT_W, 16: width of status counters.
- RST_PERIOD, 256: cycles in RUN between automatic FIFO resets. 0 disables automatic resets.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: enables write/read triggering.
- mode, in, 2: sequence mode. Latched at reset release and at each FIFO-reset completion.
- w_throttle, in, 4: write throttle value T.
- r_throttle, in, 4: read throttle value T.
- rst_req, in, 1: one-cycle pulse that requests a FIFO reset sequence.
- w_trigger, out, 1: write strobe to the FIFO.
- w_data, out, W: write data.
- w_ready, in, 1: FIFO can accept.
- r_trigger, out, 1: read strobe to the FIFO.
- r_data, in, W: read data.
- r_ready, in, 1: FIFO has data.
- fifo_rst, out, 1: FIFO reset request; toggle.
- fifo_rst_done, in, 1: FIFO reset completion; toggle, may be asynchronous.
- busy, out, 1: high outside RUN.
- err, out, 1: sticky mismatch flag.
- err_count, out, CNT_W: mismatch count; saturates at all-ones.
- rd_count, out, CNT_W: accepted-read count; wraps.
- exp_data, out, W: expected word at the first mismatch.
- got_data, out, W: received word at the first mismatch.

## Operation
- A write transfer occurs on a clk edge where w_trigger=1 and w_ready=1. A read transfer uses r_trigger and r_ready in the same way.
- The generator register g and the checker register e each follow the latched mode:
  - mode 0: seed 0, next = v+1 mod 2^W, output v.
  - mode 1: seed all-ones, next = v-1 mod 2^W, output v.
  - mode 2: seed 1, next = rotate-left(v,1), output v.
  - mode 3: seed 0, next = v+1, output v^(v>>1) (Gray code).
- w_data = output(g). g advances only on a write transfer.
- On a read transfer, r_data is compared with output(e), and then e advances. There is no resync: a lost word produces a mismatch on every following word until the next reset.
- On a mismatch:
  - err_count increments (saturating).
  - On the first mismatch since rst, err sets and exp_data/got_data capture the two words.
  - err, exp_data and got_data are cleared only by rst.
- Throttle uses a free-running 4-bit phase counter p. w_trigger may assert only when p >= w_throttle; r_trigger likewise with r_throttle. A throttle value of 0 means unthrottled.
- State machine:
  - RUN: w_trigger = en && throttle-ok; r_trigger likewise. Go to STOP when rst_req=1 or when the period counter reaches RST_PERIOD-1 (RST_PERIOD≠0). The period counter counts cycles in RUN and clears on entering RUN.
  - STOP: both triggers 0, for exactly 1 cycle. Go to RST.
  - RST: toggle fifo_rst once. Go to WAIT.
  - WAIT: wait for a toggle of fifo_rst_done, detected through a 2-flop synchroniser plus edge detect. On detection: g and e load the seed for the newly latched mode; go to RUN.
- rst_req outside RUN is ignored. rst_req coincident with period expiry causes a single sequence.

## Timing
- Reset values while rst=1:
  - state RUN, all triggers 0.
  - fifo_rst 0, busy 0, err 0.
  - counters 0, exp_data 0, got_data 0.
  - p 0.
  - mode latched from the input; g and e = seed.
  - synchroniser flops 0.
- Triggers are registered. They assert in the first cycle after rst release when en=1 and T=0.
- w_data updates in the cycle after a write transfer. Back-to-back transfers are supported: one word per cycle.
- err, err_count, exp_data and got_data update in the cycle after the mismatching read.
- fifo_rst toggles 2 cycles after the STOP decision.
- Done detection is 3 cycles after the fifo_rst_done edge. RUN triggers can assert in the next cycle.
- Async rst in any state, including mid-sequence, returns immediately to the reset values. A fifo_rst_done toggle pending at that moment is discarded.

## Test plan
- W=8, mode 0, T=0, ideal 4-deep sync FIFO model, RST_PERIOD=0, 300 reads -> words 00..FF then 00..2B; err=0; rd_count=300.
- W=8, mode 2 -> w_data sequence 01,02,04,...,80,01; mode 3 -> 00,01,03,02,06; err=0.
- Mode 0 with the FIFO model dropping the 5th word (04) -> got 05 against expected 04; err=1 one cycle later; exp_data=04, got_data=05; err_count=N after N further reads.
- RST_PERIOD=64, model returns the done toggle 10 cycles after fifo_rst -> triggers 0 during STOP/RST/WAIT; fifo_rst toggles once; busy high; the first word after the sequence is 00 and is checked; err=0.
- rst_req pulse while in WAIT -> ignored. rst asserted in WAIT -> fifo_rst=0, busy=0 immediately; after release, the first word is 00.
- w_throttle=12, r_throttle=0 -> w_trigger high on at most 4 of every 16 cycles; data remains in order; err=0.
